// File: rtl/ram32_ctrl_pkg.sv
// Shared types, widths and helpers for the SPRAM-backed
// 32-bit memory controller.
package pkg_ram;

  localparam int RAM_ADDRW    = 17;
  localparam int SPRAM_ADDRW  = 14;
  localparam int RAM_BANK_BIT = 16;

  typedef enum logic [1:0] {
    RAM_NOP,
    RAM_FETCH,
    RAM_STORE
  } op_t;

  typedef enum logic [1:0] {
    RAM_BYTE,
    RAM_WORD,
    RAM_LONG
  } data_type_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_RESP
  } ctrl_state_t;

  function automatic logic ram_size_ok(
    input data_type_t t,
    input logic [1:0] off
  );
    logic ok;
    case (t)
      RAM_BYTE: ok = 1'b1;
      RAM_WORD: ok = ~off[0];
      RAM_LONG: ok = (off == 2'b00);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Two nibbles per byte lane, starting at the byte offset
  function automatic logic [7:0] ram_nibble_mask(
    input data_type_t t,
    input logic [1:0] off
  );
    logic [7:0] m;
    case (t)
      RAM_BYTE: m = 8'h03 << {off, 1'b0};
      RAM_WORD: m = 8'h0F << {off, 1'b0};
      RAM_LONG: m = 8'hFF;
      default:  m = 8'h00;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] ram_lanes(
    input data_type_t t,
    input logic [31:0] d
  );
    logic [31:0] l;
    case (t)
      RAM_BYTE: l = {4{d[7:0]}};
      RAM_WORD: l = {2{d[15:0]}};
      default:  l = d;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/ram32_ctrl_spram.sv
// One 16K x 16 SPRAM block: hard macro on iCE40,
// behavioural array with registered read otherwise.
module ram_spram_block
  import pkg_ram::*;
(
  input  logic                   clk,
  input  logic [SPRAM_ADDRW-1:0] i_addr,
  input  logic [15:0]            i_wdata,
  input  logic [3:0]             i_maskwren,
  input  logic                   i_wren,
  input  logic                   i_cs,
  output logic [15:0]            o_rdata
);

`ifdef RAM_USE_SB_SPRAM
  SB_SPRAM256KA u_spram (
    .ADDRESS    (i_addr),
    .DATAIN     (i_wdata),
    .MASKWREN   (i_maskwren),
    .WREN       (i_wren),
    .CHIPSELECT (i_cs),
    .CLOCK      (clk),
    .STANDBY    (1'b0),
    .SLEEP      (1'b0),
    .POWEROFF   (1'b1),
    .DATAOUT    (o_rdata)
  );
`else
  logic [15:0] r_mem [2**SPRAM_ADDRW];
  logic [15:0] r_q;

  // Output only updates on a selected read, like the macro
  always_ff @(posedge clk) begin
    if (i_cs && i_wren) begin
      for (int n = 0; n < 4; n++) begin
        if (i_maskwren[n])
          r_mem[i_addr][4*n +: 4] <= i_wdata[4*n +: 4];
      end
    end else if (i_cs) begin
      r_q <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_q;
`endif

endmodule

// File: rtl/ram32_ctrl.sv
// Byte-addressed 32-bit controller over four SPRAM blocks,
// two 32-bit banks, one request in flight at a time.
module ram32_ctrl
  import pkg_ram::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  op_t                  req_op,
  input  data_type_t           req_type,
  input  logic [RAM_ADDRW-1:0] req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err
);

  ctrl_state_t r_state;
  ctrl_state_t w_next;

  logic        w_accept;
  logic        w_fetch;
  logic        w_store;
  logic        w_ok;
  logic        w_go;
  logic        w_bank;
  logic [1:0]  w_off;
  logic [7:0]  w_mask;
  logic [31:0] w_lanes;
  logic [3:0]  w_cs;
  logic [15:0] w_q [4];

  logic [SPRAM_ADDRW-1:0] w_waddr;

  logic        r_bank;
  logic [1:0]  r_off;
  data_type_t  r_type;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] w_word;
  logic [31:0] w_shift;
  logic [31:0] w_fdata;

  assign w_fetch = (req_op == RAM_FETCH);
  assign w_store = (req_op == RAM_STORE);
  assign w_bank  = req_addr[RAM_BANK_BIT];
  assign w_waddr = req_addr[RAM_BANK_BIT-1:2];
  assign w_off   = req_addr[1:0];
  assign w_mask  = ram_nibble_mask(req_type, w_off);
  assign w_lanes = ram_lanes(req_type, req_wdata);

  // Only memory ops can be misaligned
  assign w_ok = ram_size_ok(req_type, w_off)
              || !(w_fetch || w_store);
  assign w_go = w_accept && w_ok && (w_fetch || w_store);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    w_accept  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        w_accept  = req_valid && !rst;
        if (w_accept)
          w_next = (w_fetch && w_ok) ? ST_READ : ST_RESP;
      end
      ST_READ: w_next = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  for (genvar g = 0; g < 4; g++) begin : g_blk
    assign w_cs[g] = w_go && (w_bank == 1'(g / 2));

    ram_spram_block u_blk (
      .clk        (clk),
      .i_addr     (w_waddr),
      .i_wdata    (w_lanes[16*(g%2) +: 16]),
      .i_maskwren (w_mask[4*(g%2) +: 4]),
      .i_wren     (w_cs[g] && w_store),
      .i_cs       (w_cs[g]),
      .o_rdata    (w_q[g])
    );
  end

  assign w_word  = r_bank ? {w_q[3], w_q[2]}
                          : {w_q[1], w_q[0]};
  assign w_shift = w_word >> {r_off, 3'b000};

  always_comb begin
    w_fdata = w_shift;
    case (r_type)
      RAM_BYTE: w_fdata = {24'h0, w_shift[7:0]};
      RAM_WORD: w_fdata = {16'h0, w_shift[15:0]};
      default:  w_fdata = w_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank  <= 1'b0;
      r_off   <= 2'b00;
      r_type  <= RAM_BYTE;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_bank  <= w_bank;
      r_off   <= w_off;
      r_type  <= req_type;
      r_rdata <= 32'h0;
      r_err   <= !w_ok;
    end else if (r_state == ST_READ) begin
      r_rdata <= w_fdata;
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_ram32_ctrl.sv
// Directed and randomized checks of ram32_ctrl against a
// flat byte-array memory model.
module tb_ram32_ctrl;
  import pkg_ram::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  op_t         req_op = RAM_NOP;
  data_type_t  req_type = RAM_BYTE;
  logic [16:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mdl [0:(1<<17)-1];

  always #5 clk = ~clk;

  ram32_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_type  (req_type),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h",
               tag, obs, exp);
    end
  endtask

  function automatic int sz(input data_type_t t);
    return (t == RAM_BYTE) ? 1 : (t == RAM_WORD) ? 2 : 4;
  endfunction

  function automatic bit aligned(input data_type_t t,
                                 input logic [16:0] a);
    return (int'(a) % sz(t)) == 0;
  endfunction

  function automatic logic [31:0] mfetch(input data_type_t t,
                                         input logic [16:0] a);
    logic [31:0] v = 0;
    for (int i = 0; i < sz(t); i++)
      v = v + (32'(mdl[int'(a) + i]) << (8 * i));
    return v;
  endfunction

  task automatic mstore(input data_type_t t,
                        input logic [16:0] a,
                        input logic [31:0] d);
    for (int i = 0; i < sz(t); i++)
      mdl[int'(a) + i] = d[8*i +: 8];
  endtask

  task automatic xact(input string tag, input op_t op,
                      input data_type_t t,
                      input logic [16:0] a,
                      input logic [31:0] wd);
    bit ok;
    logic [31:0] exp_rd;
    int exp_lat, lat, n;
    ok = (op == RAM_NOP) || aligned(t, a);
    exp_lat = (op == RAM_FETCH && ok) ? 2 : 1;
    exp_rd = 0;
    if (op == RAM_FETCH && ok) exp_rd = mfetch(t, a);
    if (op == RAM_STORE && ok) mstore(t, a, wd);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_type = t;
    req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk); n++;
    end
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk); lat++;
    end while (!rsp_valid && lat < 8);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " err"}, 32'(rsp_err), 32'(!ok));
    chk({tag, " rdata"}, rsp_rdata, exp_rd);
    @(negedge clk);
    chk({tag, " pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [16:0] a;
    logic [16:0] bases [3];
    data_type_t t;
    int r;
    bases[0] = 17'h00400;
    bases[1] = 17'h0FFC0;
    bases[2] = 17'h1FFC0;

    repeat (3) @(negedge clk);
    chk("rst ready", 32'(req_ready), 32'd1);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rdata", rsp_rdata, 32'd0);
    chk("rst err", 32'(rsp_err), 32'd0);
    rst = 1'b0;

    xact("st long", RAM_STORE, RAM_LONG, 17'h00104, 32'hDEADBEEF);
    xact("ld long", RAM_FETCH, RAM_LONG, 17'h00104, 0);

    xact("st b0", RAM_STORE, RAM_BYTE, 17'h00200, 32'hFFFFFF11);
    xact("st b1", RAM_STORE, RAM_BYTE, 17'h00201, 32'h00000022);
    xact("st b2", RAM_STORE, RAM_BYTE, 17'h00202, 32'hABCDEF33);
    xact("st b3", RAM_STORE, RAM_BYTE, 17'h00203, 32'h00000044);
    xact("ld merge", RAM_FETCH, RAM_LONG, 17'h00200, 0);
    chk("merge const", mfetch(RAM_LONG, 17'h00200), 32'h44332211);
    xact("ld b2", RAM_FETCH, RAM_BYTE, 17'h00202, 0);
    xact("ld w2", RAM_FETCH, RAM_WORD, 17'h00202, 0);

    xact("st bank0", RAM_STORE, RAM_LONG, 17'h00008, 32'hAAAAAAAA);
    xact("st bank1", RAM_STORE, RAM_LONG, 17'h10008, 32'h55555555);
    xact("ld bank0", RAM_FETCH, RAM_LONG, 17'h00008, 0);
    xact("ld bank1", RAM_FETCH, RAM_LONG, 17'h10008, 0);
    xact("st edge0", RAM_STORE, RAM_LONG, 17'h0FFFC, 32'h01234567);
    xact("st edge1", RAM_STORE, RAM_LONG, 17'h10000, 32'h89ABCDEF);
    xact("ld edge0", RAM_FETCH, RAM_LONG, 17'h0FFFC, 0);
    xact("ld edge1", RAM_FETCH, RAM_LONG, 17'h10000, 0);
    xact("st top", RAM_STORE, RAM_BYTE, 17'h1FFFF, 32'h0000005A);
    xact("ld top", RAM_FETCH, RAM_BYTE, 17'h1FFFF, 0);

    xact("st base", RAM_STORE, RAM_LONG, 17'h00300, 32'hCAFEF00D);
    xact("st w mis", RAM_STORE, RAM_WORD, 17'h00301, 32'h00001234);
    xact("st l mis", RAM_STORE, RAM_LONG, 17'h00302, 32'h87654321);
    xact("ld l mis", RAM_FETCH, RAM_LONG, 17'h00301, 0);
    xact("ld after mis", RAM_FETCH, RAM_LONG, 17'h00300, 0);
    xact("nop", RAM_NOP, RAM_LONG, 17'h00300, 0);

    // Request held across ST_READ must wait for ST_IDLE
    @(negedge clk);
    req_valid = 1'b1; req_op = RAM_FETCH; req_type = RAM_LONG;
    req_addr = 17'h00104;
    @(posedge clk);
    #1 req_op = RAM_STORE; req_addr = 17'h00108;
    req_wdata = 32'h12345678;
    @(negedge clk);
    chk("hs read ready", 32'(req_ready), 32'd0);
    chk("hs read valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("hs resp valid", 32'(rsp_valid), 32'd1);
    chk("hs resp ready", 32'(req_ready), 32'd0);
    chk("hs resp rdata", rsp_rdata, mfetch(RAM_LONG, 17'h00104));
    @(negedge clk);
    chk("hs idle ready", 32'(req_ready), 32'd1);
    mstore(RAM_LONG, 17'h00108, 32'h12345678);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("hs st valid", 32'(rsp_valid), 32'd1);
    chk("hs st err", 32'(rsp_err), 32'd0);
    xact("ld hs", RAM_FETCH, RAM_LONG, 17'h00108, 0);

    // Reset mid-fetch abandons the response
    @(negedge clk);
    req_valid = 1'b1; req_op = RAM_FETCH; req_type = RAM_LONG;
    req_addr = 17'h00200;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst mid valid", 32'(rsp_valid), 32'd0);
    chk("rst mid ready", 32'(req_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst mid after", 32'(rsp_valid), 32'd0);
    xact("ld after rst", RAM_FETCH, RAM_LONG, 17'h00200, 0);

    // A store presented during reset must not write
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b1; req_op = RAM_STORE;
    req_type = RAM_LONG; req_addr = 17'h00104; req_wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst hold valid", 32'(rsp_valid), 32'd0);
    chk("rst hold ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0; rst = 1'b0;
    xact("ld no wr", RAM_FETCH, RAM_LONG, 17'h00104, 0);

    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 16; i++)
        xact("init", RAM_STORE, RAM_LONG,
             bases[b] + 17'(4 * i), $urandom);

    for (int i = 0; i < 80; i++) begin
      a = bases[$urandom_range(0, 2)] + 17'($urandom_range(0, 63));
      t = data_type_t'($urandom_range(0, 2));
      r = $urandom_range(0, 9);
      if (r < 5)      xact("rnd ld", RAM_FETCH, t, a, 0);
      else if (r < 9) xact("rnd st", RAM_STORE, t, a, $urandom);
      else            xact("rnd nop", RAM_NOP, t, a, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram32_ctrl.md
# ram32_ctrl

Byte-addressed 32-bit memory controller for the four iCE40 SPRAM blocks (16K x 16 each), presenting 128 KiB as two 32-bit banks. It accepts one request at a time (fetch/store of byte, word or long) from the core-side requester over a valid/ready handshake. It translates each request into SPRAM chip-select, nibble-mask and data-lane signals, and returns a one-cycle response pulse carrying right-justified, zero-extended fetch data or an alignment error.

## Interface
Parameters:
- none. All widths come from `pkg_ram`.

Ports:
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `rst`  in  1  — reset is synchronous and active-high.
- `req_valid`  in  1  — request present; the requester holds all `req_*` stable until accepted.
- `req_ready`  out  1  — controller can accept; the request is accepted on any edge where `req_valid && req_ready`.
- `req_op`  in  `op_t`  — `RAM_NOP`, `RAM_FETCH` or `RAM_STORE`.
- `req_type`  in  `data_type_t`  — `RAM_BYTE`, `RAM_WORD` or `RAM_LONG`.
- `req_addr`  in  `RAM_ADDRW` (17)  — byte address.
- `req_wdata`  in  32  — store data, right-justified; bits above the access size are ignored.
- `rsp_valid`  out  1  — one-cycle response pulse; there is no backpressure.
- `rsp_rdata`  out  32  — fetch result, zero-extended; 0 for store, NOP or error.
- `rsp_err`  out  1  — misaligned access; qualified by `rsp_valid`.

## Operation
Address split:
- `req_addr[16]` selects the bank.
- `req_addr[15:2]` is the SPRAM word address (`SPRAM_ADDRW`).
- `req_addr[1:0]` is the byte offset `k`.
- Bank b uses block 2b for bits 15:0 and block 2b+1 for bits 31:16.

Alignment:
- `RAM_WORD` requires `addr[0]=0`; `RAM_LONG` requires `addr[1:0]=0`.
- A misaligned request is accepted, drives no write and no chip-select, and gets `rsp_err=1` and `rsp_rdata=0`.

Store:
- Data is replicated into lanes: byte into all four byte lanes, word into both halves.
- Nibble write mask enables only bytes `k .. k+size-1` (byte: 2 nibbles, word: 4, long: 8).
- Only the two blocks of the selected bank are chip-selected.

Fetch:
- The 32-bit bank word is captured and shifted right by 8·k.
- The result is masked to 8/16/32 bits.

NOP: accepted; the response carries `rdata=0`, `err=0`.

FSM states `ST_IDLE`, `ST_READ`, `ST_RESP`:
- `ST_IDLE`: `req_ready=1`.
  - Accepting a fetch (aligned) → `ST_READ`.
  - Accepting a store, NOP or any misaligned request → `ST_RESP`.
  - No request → stay in `ST_IDLE`.
- `ST_READ`: SPRAM output is valid; capture, shift and mask into `rsp_rdata`. → `ST_RESP`.
- `ST_RESP`: `rsp_valid=1`. → `ST_IDLE`.
- `req_ready=0` outside `ST_IDLE`; `req_valid` is ignored there.

## Timing
- SPRAM address, data, mask and write-enable are driven combinationally from `req_*` in the accept cycle; the SPRAM samples them at the accept edge.
- Store: the write happens at the accept edge (A); `rsp_valid` is high in cycle A+1.
- Fetch: SPRAM data is valid in A+1 and registered at the end of A+1; `rsp_valid` is high in A+2.
- NOP or misaligned: `rsp_valid` is high in A+1.
- Throughput: one store per 2 cycles, one fetch per 3 cycles. Back-to-back acceptance is possible on the cycle after `rsp_valid`.
- `rsp_rdata` and `rsp_err` hold their values until the next response; they are only meaningful with `rsp_valid`.
- Reset values: state `ST_IDLE`, `req_ready=1` (combinational from state), `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`.
- While `rst=1`: all SPRAM write-enables and chip-selects are forced to 0, and no request is accepted.
- Reset mid-operation abandons the request: no `rsp_valid`, and a store already written stays written.
- SPRAM contents are not cleared by reset.
- Bank boundary: address 0x0FFFC (long) is bank 0 and 0x10000 is bank 1. Address 0x1FFFF with a byte access is legal; there is no wrap.

## Structure
Add to `pkg_ram`:
- `RAM_BANK_BIT = 16`.
- State enum `ctrl_state_t { ST_IDLE, ST_READ, ST_RESP }`.
- Function `ram_nibble_mask(data_type_t, offset)` returning an 8-bit mask.
- Function `ram_size_ok(data_type_t, offset)` for the alignment check.

Sub-module `ram_spram_block`:
- Wraps one `SB_SPRAM256KA` (addr 14, data 16, `maskwren` 4, `wren`, `chipselect`); standby, sleep and poweroff are tied inactive.
- Instantiated four times.
- Has a behavioural model for simulation: a 16K x 16 array with registered read and per-nibble write.

## Test plan
- Reset: hold `rst` 3 cycles → `rsp_valid=0`, `req_ready=1`, no SPRAM `wren` asserted.
- Long round trip: store long 0xDEADBEEF @0x00104, then fetch long @0x00104 → `rsp_valid` at A+1 for the store, then at A+2 for the fetch with `rdata=0xDEADBEEF`, `err=0`.
- Byte merge: store bytes 0x11, 0x22, 0x33, 0x44 @0x00200–0x00203, then fetch long @0x00200 → `0x44332211`; fetch byte @0x00202 → `0x00000033`; fetch word @0x00202 → `0x00004433`.
- Bank isolation: store long 0xAAAAAAAA @0x00008 and 0x55555555 @0x10008 → fetches return each value unchanged.
- Misalignment: store word @0x00301 and store long @0x00302 → `rsp_err=1` at A+1 with `rdata=0`; a subsequent fetch long @0x00300 returns the previously stored value.
- Handshake and reset mid-fetch: `req_valid` held during `ST_READ` is not accepted until `ST_IDLE`. Asserting `rst` in `ST_READ` → no `rsp_valid`, and the next request is accepted normally.
